// File: rtl/npc_ras.sv
// npc_ras: next-PC selection for the fetch stage with a circular
// return-address stack that predicts `jr $ra` targets and keeps
// saturating hit/miss statistics. The RAS is advisory only; it never
// changes the PC that gets loaded.
module npc_ras #(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [AW-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int unsigned   RAS_DEPTH = 4,
  parameter int unsigned   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             exception,
  input  logic             eret,
  input  logic [AW-1:0]    epc,
  input  logic             jal,
  input  logic [25:0]      instr_index,
  input  logic             jr,
  input  logic             jr_is_ret,
  input  logic [AW-1:0]    jr_target,
  input  logic             br_taken,
  input  logic [15:0]      imm,
  output logic [AW-1:0]    pc,
  output logic [2:0]       npc_sel,
  output logic [AW-1:0]    ras_pred,
  output logic             ras_valid,
  output logic             jr_misalign,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic [CNT_W-1:0] ret_hit_cnt,
  output logic [CNT_W-1:0] ret_miss_cnt
);

  localparam int unsigned   PW   = $clog2(RAS_DEPTH);
  localparam int unsigned   CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_PLUS4 = 3'd0,
    SEL_BR    = 3'd1,
    SEL_JAL   = 3'd2,
    SEL_JR    = 3'd3,
    SEL_EXC   = 3'd4,
    SEL_EPC   = 3'd5
  } sel_e;

  sel_e             sel;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    ras_q [RAS_DEPTH];
  logic [AW-1:0]    ras_d [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d, top_inc;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;

  logic             adv, do_push, do_pop;
  logic [AW-1:0]    pc_plus4, br_off, br_target, jal_target, next_pc;

  // Fixed-priority source selection from the current-cycle controls
  always_comb begin
    if (exception)     sel = SEL_EXC;
    else if (eret)     sel = SEL_EPC;
    else if (jal)      sel = SEL_JAL;
    else if (jr)       sel = SEL_JR;
    else if (br_taken) sel = SEL_BR;
    else               sel = SEL_PLUS4;
  end

  assign npc_sel  = sel;
  assign adv      = pc_en | exception;
  assign pc_plus4 = pc_q + AW'(4);
  assign br_off   = {{(AW-18){imm[15]}}, imm, 2'b00};
  assign br_target = pc_q + br_off;

  // Jump target keeps the PC's upper region and replaces the low 28 bits
  always_comb begin
    jal_target        = pc_q;
    jal_target[27:0]  = {instr_index, 2'b00};
  end

  // Candidate next PC for the selected source
  always_comb begin
    case (sel)
      SEL_PLUS4: next_pc = pc_plus4;
      SEL_BR:    next_pc = br_target;
      SEL_JAL:   next_pc = jal_target;
      SEL_JR:    next_pc = jr_target;
      SEL_EXC:   next_pc = EXC_VEC;
      SEL_EPC:   next_pc = epc;
      default:   next_pc = '0;
    endcase
  end

  // PC advances only when enabled or on exception entry
  always_comb begin
    pc_d = adv ? next_pc : pc_q;
  end

  assign do_push   = adv && (sel == SEL_JAL);
  assign do_pop    = adv && (sel == SEL_JR) && jr_is_ret;
  assign ras_valid = (cnt_q != '0);
  assign ras_pred  = ras_valid ? ras_q[top_q] : '0;
  assign top_inc   = top_q + PW'(1);

  // Stack storage, top pointer, occupancy and overflow flag
  always_comb begin
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (do_push) begin
      ras_d[top_inc] = pc_plus4;
      top_d          = top_inc;
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + CW'(1);
    end else if (do_pop && ras_valid) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Return statistics and underflow flag; a pop on empty counts as a miss
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    unf_d  = unf_q;
    if (do_pop) begin
      if (ras_valid && (ras_pred == jr_target)) begin
        if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
      end else begin
        if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
        if (!ras_valid)   unf_d  = 1'b1;
      end
    end
  end

  // Misalignment flag refreshed on every enabled jr, held otherwise
  always_comb begin
    mis_d = mis_q;
    if (adv && (sel == SEL_JR)) mis_d = |jr_target[1:0];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_VEC;
      top_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= '0;
      miss_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      mis_q  <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      mis_q  <= mis_d;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

  assign pc           = pc_q;
  assign jr_misalign  = mis_q;
  assign ras_ovf      = ovf_q;
  assign ras_unf      = unf_q;
  assign ret_hit_cnt  = hit_q;
  assign ret_miss_cnt = miss_q;

endmodule

// File: tb/tb_npc_ras.sv
// Bench for npc_ras: two instances (default counters and 2-bit counters)
// share one directed stimulus; a queue-based stack model predicts every
// output each cycle, and literal expectations pin key points.
module tb_npc_ras;

  logic        clk;
  logic        reset, pc_en, exception, eret, jal, jr, jr_is_ret, br_taken;
  logic [31:0] epc, jr_target;
  logic [25:0] instr_index;
  logic [15:0] imm;

  logic [31:0] pc_a, pred_a, pc_b, pred_b;
  logic [2:0]  sel_a, sel_b;
  logic        valid_a, mis_a, ovf_a, unf_a, valid_b, mis_b, ovf_b, unf_b;
  logic [15:0] hit_a, miss_a;
  logic [1:0]  hit_b, miss_b;

  int checks = 0;
  int errors = 0;

  npc_ras dut_a (
    .clk(clk), .reset(reset), .pc_en(pc_en), .exception(exception),
    .eret(eret), .epc(epc), .jal(jal), .instr_index(instr_index),
    .jr(jr), .jr_is_ret(jr_is_ret), .jr_target(jr_target),
    .br_taken(br_taken), .imm(imm), .pc(pc_a), .npc_sel(sel_a),
    .ras_pred(pred_a), .ras_valid(valid_a), .jr_misalign(mis_a),
    .ras_ovf(ovf_a), .ras_unf(unf_a), .ret_hit_cnt(hit_a),
    .ret_miss_cnt(miss_a)
  );

  npc_ras #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .pc_en(pc_en), .exception(exception),
    .eret(eret), .epc(epc), .jal(jal), .instr_index(instr_index),
    .jr(jr), .jr_is_ret(jr_is_ret), .jr_target(jr_target),
    .br_taken(br_taken), .imm(imm), .pc(pc_b), .npc_sel(sel_b),
    .ras_pred(pred_b), .ras_valid(valid_b), .jr_misalign(mis_b),
    .ras_ovf(ovf_b), .ras_unf(unf_b), .ret_hit_cnt(hit_b),
    .ret_miss_cnt(miss_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: the stack is a plain queue, newest entry at the back
  logic [31:0] m_pc;
  logic [31:0] m_stk [$];
  int          m_hits, m_miss;
  logic        m_ovf, m_unf, m_mis, m_ok;

  initial m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_sel();
    if (exception)     return 3'd4;
    else if (eret)     return 3'd5;
    else if (jal)      return 3'd2;
    else if (jr)       return 3'd3;
    else if (br_taken) return 3'd1;
    else               return 3'd0;
  endfunction

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] nxt;
    logic [2:0]  s;
    if (!reset) begin
      m_pc   = 32'h3000;
      m_stk.delete();
      m_hits = 0;
      m_miss = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_mis  = 1'b0;
      m_ok   = 1'b1;
    end else if (pc_en || exception) begin
      s = exp_sel();
      case (s)
        3'd0:    nxt = m_pc + 32'd4;
        3'd1:    nxt = m_pc + {{14{imm[15]}}, imm, 2'b00};
        3'd2:    nxt = {m_pc[31:28], instr_index, 2'b00};
        3'd3:    nxt = jr_target;
        3'd4:    nxt = 32'h0000_4180;
        default: nxt = epc;
      endcase
      if (s == 3'd2) begin
        if (m_stk.size() == 4) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_stk.push_back(m_pc + 32'd4);
      end
      if (s == 3'd3) begin
        m_mis = (jr_target[1:0] != 2'b00);
        if (jr_is_ret) begin
          if (m_stk.size() > 0) begin
            if (m_stk[$] == jr_target) m_hits++;
            else                       m_miss++;
            void'(m_stk.pop_back());
          end else begin
            m_miss++;
            m_unf = 1'b1;
          end
        end
      end
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ep;
    if (m_ok) begin
      ep = (m_stk.size() > 0) ? m_stk[$] : 32'h0;
      chk("pc_a",    pc_a,    m_pc);
      chk("sel_a",   32'(sel_a), 32'(exp_sel()));
      chk("pred_a",  pred_a,  ep);
      chk("valid_a", 32'(valid_a), 32'(m_stk.size() > 0));
      chk("mis_a",   32'(mis_a), 32'(m_mis));
      chk("ovf_a",   32'(ovf_a), 32'(m_ovf));
      chk("unf_a",   32'(unf_a), 32'(m_unf));
      chk("hit_a",   32'(hit_a),  sat(m_hits, 65535));
      chk("miss_a",  32'(miss_a), sat(m_miss, 65535));
      chk("pc_b",    pc_b,    m_pc);
      chk("pred_b",  pred_b,  ep);
      chk("hit_b",   32'(hit_b),  sat(m_hits, 3));
      chk("miss_b",  32'(miss_b), sat(m_miss, 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rets [5];

  initial begin
    rets = '{32'h5304, 32'h5204, 32'h5104, 32'h5004, 32'h3008};
    reset = 1'b0; pc_en = 1'b0; exception = 1'b0; eret = 1'b0; epc = '0;
    jal = 1'b0; instr_index = '0; jr = 1'b0; jr_is_ret = 1'b0;
    jr_target = '0; br_taken = 1'b0; imm = '0;

    // reset held two edges, then sequential fetch
    tick(); tick();
    reset = 1'b1; pc_en = 1'b1;
    chk("rst_pc", pc_a, 32'h3000);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_hit", 32'(hit_a), 0);
    tick(); chk("seq1", pc_a, 32'h3004);
    tick(); chk("seq2", pc_a, 32'h3008);
    tick(); tick(); chk("at3010", pc_a, 32'h3010);

    // backward branch of -16
    br_taken = 1'b1; imm = 16'hFFFC; #1;
    chk("br_sel", 32'(sel_a), 1);
    tick(); chk("br_pc", pc_a, 32'h3000);
    br_taken = 1'b0;

    // call then matching return
    jal = 1'b1; instr_index = 26'h0000C10;
    tick(); chk("jal_pc", pc_a, 32'h3040);
    jal = 1'b0; jr = 1'b1; jr_is_ret = 1'b1; jr_target = 32'h3004; #1;
    chk("ret_pred", pred_a, 32'h3004);
    tick();
    chk("ret_pc", pc_a, 32'h3004);
    chk("ret_hit", 32'(hit_a), 1);
    chk("ret_empty", 32'(valid_a), 0);
    jr = 1'b0; jr_is_ret = 1'b0;

    // five nested calls overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      jal = 1'b1; instr_index = 26'h1400 + 26'(i * 'h40);
      tick(); chk("nest_pc", pc_a, 32'h5000 + 32'(i * 'h100));
    end
    jal = 1'b0;
    chk("ovf", 32'(ovf_a), 1);
    jr = 1'b1; jr_is_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      jr_target = rets[i];
      tick();
    end
    chk("hits4", 32'(hit_a), 5);
    chk("unf_pre", 32'(unf_a), 0);
    jr_target = rets[4];
    tick();
    chk("miss5", 32'(miss_a), 1);
    chk("unf", 32'(unf_a), 1);
    chk("hit_sat_b", 32'(hit_b), 3);
    chk("ret5_pc", pc_a, 32'h3008);
    jr = 1'b0; jr_is_ret = 1'b0;

    // exception under stall beats jal and leaves the stack alone
    jal = 1'b1; instr_index = 26'h1400;
    tick(); chk("push_pred", pred_a, 32'h300C);
    pc_en = 1'b0; exception = 1'b1; #1;
    chk("exc_sel", 32'(sel_a), 4);
    tick();
    chk("exc_pc", pc_a, 32'h4180);
    chk("exc_pred", pred_a, 32'h300C);
    exception = 1'b0; jal = 1'b0; pc_en = 1'b1; eret = 1'b1; epc = 32'h3020; #1;
    chk("eret_sel", 32'(sel_a), 5);
    tick(); chk("eret_pc", pc_a, 32'h3020);
    eret = 1'b0; pc_en = 1'b0; jal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_pc", pc_a, 32'h3020);
    end
    chk("stall_pred", pred_a, 32'h300C);
    jal = 1'b0; pc_en = 1'b1;

    // mismatched returns saturate the 2-bit miss counter
    jr = 1'b1; jr_is_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      jr_target = 32'h7000 + 32'(i * 'h10);
      tick();
    end
    chk("miss_sat_b", 32'(miss_b), 3);
    chk("miss_a5", 32'(miss_a), 5);

    // misaligned jr target is still loaded
    jr_is_ret = 1'b0; jr_target = 32'h3006;
    tick();
    chk("mis_set", 32'(mis_a), 1);
    chk("mis_pc", pc_a, 32'h3006);
    jr = 1'b0;
    tick(); chk("mis_hold", 32'(mis_a), 1);
    jr = 1'b1; jr_target = 32'h3008;
    tick(); chk("mis_clr", 32'(mis_a), 0);

    // silent PC wrap-around
    jr_target = 32'hFFFF_FFFC;
    tick(); jr = 1'b0;
    tick(); chk("wrap_pc", pc_a, 32'h0);

    // jal and jr together: jal wins and pushes
    jal = 1'b1; jr = 1'b1; jr_is_ret = 1'b1; instr_index = 26'h1400; #1;
    chk("jaljr_sel", 32'(sel_a), 2);
    tick();
    chk("jaljr_pc", pc_a, 32'h5000);
    chk("jaljr_pred", pred_a, 32'h4);
    jr = 1'b0; jr_is_ret = 1'b0;

    // reset mid-sequence discards the pending push
    reset = 1'b0;
    tick();
    chk("mrst_pc", pc_a, 32'h3000);
    chk("mrst_valid", 32'(valid_a), 0);
    chk("mrst_ovf", 32'(ovf_a), 0);
    chk("mrst_miss", 32'(miss_a), 0);
    reset = 1'b1; jal = 1'b0;
    tick(); chk("mrst_seq", pc_a, 32'h3004);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
